// File: rtl/fixed_point_acc.sv
// rtl/fixed_point_acc.sv - saturating per-frame dot-product accumulator fed by the multiplier product stream
// Each frame: bias + NUM_TERMS products, clamped to WIDTH bits on output.
module fixed_point_acc #(
  parameter int WIDTH     = 8,
  parameter int FRAC_BITS = 3,
  parameter int NUM_TERMS = 4,
  parameter int ACC_GUARD = 3
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic [WIDTH-1:0] BIAS_IN,
  input  logic [WIDTH-1:0] VALUE_IN,
  input  logic             VALID_IN,
  input  logic             OVERFLOW_IN,
  output logic [WIDTH-1:0] VALUE_OUT,
  output logic             VALID_OUT,
  output logic             OVERFLOW,
  output logic             BUSY
);

  localparam int AW = WIDTH + ACC_GUARD;
  localparam int CW = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NUM_TERMS - 1);
  localparam logic signed [AW-1:0] SAT_MAX = AW'((1 << (WIDTH - 1)) - 1);
  localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

  // Guard bits must hold bias plus NUM_TERMS extreme products without wrapping.
  if (NUM_TERMS < 1 || FRAC_BITS >= WIDTH || (1 << ACC_GUARD) < NUM_TERMS + 1) begin : g_bad_params
    $error("fixed_point_acc: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

  state_t                 state_q, state_d;
  logic signed [AW-1:0]   acc_q, acc_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   ovf_sticky_q, ovf_sticky_d;
  logic [WIDTH-1:0]       value_q, value_d;
  logic                   valid_q, valid_d;
  logic                   ovf_out_q, ovf_out_d;

  logic signed [AW-1:0]   bias_x;
  logic signed [AW-1:0]   value_x;
  logic [WIDTH-1:0]       sat_val;
  logic                   clamp;

  assign bias_x  = {{ACC_GUARD{BIAS_IN[WIDTH-1]}}, BIAS_IN};
  assign value_x = {{ACC_GUARD{VALUE_IN[WIDTH-1]}}, VALUE_IN};

  always_comb begin
    sat_val = acc_q[WIDTH-1:0];
    clamp   = 1'b0;
    if (acc_q > SAT_MAX) begin
      sat_val = SAT_MAX[WIDTH-1:0];
      clamp   = 1'b1;
    end else if (acc_q < SAT_MIN) begin
      sat_val = SAT_MIN[WIDTH-1:0];
      clamp   = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    ovf_sticky_d = ovf_sticky_q;
    value_d      = value_q;
    valid_d      = 1'b0;
    ovf_out_d    = ovf_out_q;
    case (state_q)
      IDLE, EMIT: begin
        if (state_q == EMIT) begin
          value_d   = sat_val;
          valid_d   = 1'b1;
          ovf_out_d = ovf_sticky_q | clamp;
          state_d   = IDLE;
        end
        // A term arriving during EMIT opens the next frame without a lost cycle.
        if (VALID_IN) begin
          acc_d        = bias_x + value_x;
          ovf_sticky_d = OVERFLOW_IN;
          if (NUM_TERMS == 1) begin
            cnt_d   = '0;
            state_d = EMIT;
          end else begin
            cnt_d   = CW'(1);
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (VALID_IN) begin
          acc_d        = acc_q + value_x;
          ovf_sticky_d = ovf_sticky_q | OVERFLOW_IN;
          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            state_d = EMIT;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      cnt_q        <= '0;
      ovf_sticky_q <= 1'b0;
      value_q      <= '0;
      valid_q      <= 1'b0;
      ovf_out_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      ovf_sticky_q <= ovf_sticky_d;
      value_q      <= value_d;
      valid_q      <= valid_d;
      ovf_out_q    <= ovf_out_d;
    end
  end

  assign VALUE_OUT = value_q;
  assign VALID_OUT = valid_q;
  assign OVERFLOW  = ovf_out_q;
  assign BUSY      = (state_q == ACCUM);

endmodule

// File: tb/tb_fixed_point_acc.sv
// tb/tb_fixed_point_acc.sv - self-checking bench for fixed_point_acc with a frame-level reference model
module tb_fixed_point_acc;

  localparam int N = 4;

  logic       CLK = 1'b0;
  logic       RSTN = 1'b0;
  logic [7:0] BIAS_IN = '0;
  logic [7:0] VALUE_IN = '0;
  logic       VALID_IN = 1'b0;
  logic       OVERFLOW_IN = 1'b0;
  logic [7:0] VALUE_OUT;
  logic       VALID_OUT;
  logic       OVERFLOW;
  logic       BUSY;

  fixed_point_acc #(.WIDTH(8), .FRAC_BITS(3), .NUM_TERMS(N), .ACC_GUARD(3)) dut (
    .CLK(CLK), .RSTN(RSTN), .BIAS_IN(BIAS_IN), .VALUE_IN(VALUE_IN), .VALID_IN(VALID_IN),
    .OVERFLOW_IN(OVERFLOW_IN), .VALUE_OUT(VALUE_OUT), .VALID_OUT(VALID_OUT),
    .OVERFLOW(OVERFLOW), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int       due;
    logic [7:0] val;
    logic     ovf;
  } result_t;

  result_t    exp_q[$];
  int         edge_n = 0;
  int         checks = 0;
  int         errors = 0;
  int         pulses = 0;
  int         frame_terms = 0;
  int         frame_sum = 0;
  logic       frame_ovf = 1'b0;
  logic [7:0] held_val = '0;
  logic       held_ovf = 1'b0;
  logic       exp_valid;

  task automatic check_outputs();
    exp_valid = 1'b0;
    if (exp_q.size() != 0 && exp_q[0].due == edge_n) begin
      exp_valid = 1'b1;
      held_val  = exp_q[0].val;
      held_ovf  = exp_q[0].ovf;
      void'(exp_q.pop_front());
    end
    if (VALID_OUT === 1'b1) pulses++;
    checks++;
    assert (VALID_OUT === exp_valid) else begin
      errors++; $error("FAIL valid_out edge %0d: got %b want %b", edge_n, VALID_OUT, exp_valid);
    end
    checks++;
    assert (VALUE_OUT === held_val) else begin
      errors++; $error("FAIL value_out edge %0d: got %0d want %0d", edge_n, $signed(VALUE_OUT), $signed(held_val));
    end
    checks++;
    assert (OVERFLOW === held_ovf) else begin
      errors++; $error("FAIL overflow edge %0d: got %b want %b", edge_n, OVERFLOW, held_ovf);
    end
    checks++;
    assert (BUSY === (frame_terms != 0)) else begin
      errors++; $error("FAIL busy edge %0d: got %b want %b", edge_n, BUSY, frame_terms != 0);
    end
  endtask

  // Drive one cycle, let the model absorb it at the same edge, then check at the falling edge.
  task automatic step(input bit v, input int bias, input int val, input bit oi, input bit rst);
    result_t r;
    RSTN        = !rst;
    VALID_IN    = v;
    BIAS_IN     = 8'(bias);
    VALUE_IN    = 8'(val);
    OVERFLOW_IN = oi;
    @(posedge CLK);
    edge_n++;
    if (rst) begin
      exp_q.delete();
      frame_terms = 0;
      held_val    = '0;
      held_ovf    = 1'b0;
    end else if (v) begin
      if (frame_terms == 0) begin
        frame_sum = int'($signed(8'(bias))) + int'($signed(8'(val)));
        frame_ovf = oi;
      end else begin
        frame_sum += int'($signed(8'(val)));
        frame_ovf |= oi;
      end
      frame_terms++;
      if (frame_terms == N) begin
        r.due = edge_n + 1;
        r.ovf = frame_ovf;
        if (frame_sum > 127) begin
          r.val = 8'd127; r.ovf = 1'b1;
        end else if (frame_sum < -128) begin
          r.val = 8'h80;  r.ovf = 1'b1;
        end else begin
          r.val = 8'(frame_sum);
        end
        exp_q.push_back(r);
        frame_terms = 0;
      end
    end
    @(negedge CLK);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic check_const(input string tag, input logic [7:0] got_v, input logic got_o,
                             input logic [7:0] want_v, input logic want_o);
    checks++;
    assert (got_v === want_v && got_o === want_o) else begin
      errors++; $error("FAIL %s: got %0d/%b want %0d/%b", tag, $signed(got_v), got_o, $signed(want_v), want_o);
    end
  endtask

  initial begin
    int p0;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    idle(2);

    // Basic frame: 8 + 8 + 16 - 4 + 4 = 32
    step(1, 8, 8, 0, 0); step(1, 0, 16, 0, 0); step(1, 0, -4, 0, 0); step(1, 0, 4, 0, 0);
    idle(1);
    check_const("basic_frame", VALUE_OUT, OVERFLOW, 8'd32, 1'b0);
    checks++;
    assert (VALID_OUT === 1'b1) else begin
      errors++; $error("FAIL basic_latency: got %b want 1", VALID_OUT);
    end
    idle(2);

    for (int i = 0; i < N; i++) step(1, 0, 127, 0, 0);
    idle(1);
    check_const("pos_sat", VALUE_OUT, OVERFLOW, 8'd127, 1'b1);
    for (int i = 0; i < N; i++) step(1, 0, -128, 0, 0);
    idle(1);
    check_const("neg_sat", VALUE_OUT, OVERFLOW, 8'h80, 1'b1);

    for (int i = 1; i <= N; i++) step(1, 0, i, i == 2, 0);
    idle(1);
    check_const("sticky_ovf", VALUE_OUT, OVERFLOW, 8'd10, 1'b1);
    for (int i = 1; i <= N; i++) step(1, 0, i, 0, 0);
    idle(1);
    check_const("clean_after_sticky", VALUE_OUT, OVERFLOW, 8'd10, 1'b0);

    // Bubbles carrying a stray overflow flag must not affect the frame.
    p0 = pulses;
    for (int i = 0; i < N; i++) begin
      step(1, -8, 8, 0, 0);
      for (int b = 0; b < i; b++) step(0, 0, 0, 1, 0);
    end
    idle(3);
    check_const("bubbles", VALUE_OUT, OVERFLOW, 8'd24, 1'b0);
    checks++;
    assert (pulses - p0 == 1) else begin
      errors++; $error("FAIL bubbles_pulses: got %0d want 1", pulses - p0);
    end

    for (int i = 1; i <= 2 * N; i++) step(1, 0, i, 0, 0);
    idle(1);
    check_const("back_to_back", VALUE_OUT, OVERFLOW, 8'd26, 1'b0);
    idle(1);

    p0 = pulses;
    step(1, 0, 1, 0, 0); step(1, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1);
    check_const("reset_outputs", VALUE_OUT, OVERFLOW, 8'd0, 1'b0);
    for (int i = 0; i < N; i++) step(1, 0, 1, 0, 0);
    idle(2);
    check_const("after_reset", VALUE_OUT, OVERFLOW, 8'd4, 1'b0);
    checks++;
    assert (pulses - p0 == 1) else begin
      errors++; $error("FAIL reset_pulses: got %0d want 1", pulses - p0);
    end

    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)) - 128,
           int'($urandom_range(0, 255)) - 128, $urandom_range(0, 7) == 0,
           $urandom_range(0, 60) == 0);
    end
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
